risc16_banked_memory: RTL
=========================

# risc16_banked_memory

Parametrised byte-addressed, big-endian main memory for RiSC-16 multi-cycle and pipelined cores. It offers an instruction-fetch read port and a data read/write port with byte enables, sharing one byte array through a fair arbiter. Access latency is configurable, and a hardware clear engine zeroes the array after reset or on request.

## Interface
- `WORD_LENGTH`, 16: bits per word; a multiple of 8. `BYTES = WORD_LENGTH/8`.
- `ADDR_WIDTH`, 16: byte-address width.
- `MEM_SIZE`, 65536: bytes; a power of two, ≤ 2^ADDR_WIDTH.
- `WAIT_CYCLES`, 0: extra wait states per access (0..15).
- `INIT_CLEAR`, 1: 1 = run a clear sweep after reset release.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `clearReq` in 1: start a clear sweep; sampled only in IDLE.
- `busy` out 1: high while the clear sweep runs.
- `iReq` in 1: instruction read request; held until `iValid`.
- `iAddr` in ADDR_WIDTH: instruction byte address.
- `iData` out WORD_LENGTH: fetched word.
- `iValid` out 1: one-cycle completion pulse for the instruction port.
- `dReq` in 1: data request; held until `dValid`.
- `dWe` in 1: 1 = write, 0 = read.
- `dByteEn` in BYTES: write lane enables. The MSB is the byte at `dAddr`.
- `dAddr` in ADDR_WIDTH: data byte address.
- `dDataIn` in WORD_LENGTH: write data.
- `dDataOut` out WORD_LENGTH: read data.
- `dValid` out 1: one-cycle completion pulse for the data port.

## Operation
- **Byte layout.** A word at address A maps to bytes A, A+1, … A+BYTES-1, with the most significant byte at A.
- **Address arithmetic.** All byte addresses are computed modulo MEM_SIZE, so accesses wrap from the top of memory to byte 0. Unaligned addresses are legal.
- **FSM states:** CLEAR, IDLE, WAIT, ACCESS.
- **Reset.** Enters CLEAR if INIT_CLEAR=1, otherwise IDLE. All outputs go to 0 and the clear counter goes to 0. Reset does not itself alter the array.
- **CLEAR.** Zeroes BYTES bytes per cycle at counter×BYTES, starting from byte 0. Leaves for IDLE after MEM_SIZE/BYTES cycles. `busy` is high throughout. Requests are not granted during CLEAR; they stay pending.
- **IDLE, arbitration and capture.** `clearReq` has priority over requests and moves the FSM to CLEAR. Otherwise, if any request is pending:
  - Grant it. If both ports are requesting, grant the port not granted last; `lastGrant` resets to instruction, so data wins the first tie.
  - Capture port id, address, `dWe`, `dByteEn` and `dDataIn`.
  - Go to WAIT if WAIT_CYCLES>0, else ACCESS.
- **WAIT.** Counts WAIT_CYCLES cycles, then goes to ACCESS.
- **ACCESS, read.** Loads the addressed word into `iData` or `dDataOut`.
- **ACCESS, write.** Writes only the enabled lanes of the captured data. `dDataOut` is unchanged, and a write with `dByteEn=0` leaves the array unchanged.
- **ACCESS, completion.** Pulses the granted port's valid for one cycle, updates `lastGrant`, and returns to IDLE.
- **Output holding.** `iData` and `dDataOut` hold their values until the next read on the same port.
- **Instruction port** is read-only and never writes.
- **Data-to-instruction coherence.** A data write completing at edge E is visible to any instruction read granted at or after E.

## Timing
- A request sampled high in IDLE at edge E0 completes with valid high in the cycle after edge E0+WAIT_CYCLES+1. With WAIT_CYCLES=0, valid rises one edge after acceptance.
- A request still high at the edge ending its valid cycle is a new request. Back-to-back throughput is therefore one access per WAIT_CYCLES+2 cycles.
- A losing port waits at most one complete transaction of the other port.
- `clearReq` sampled in IDLE at edge E gives `busy`=1 from E to E+MEM_SIZE/BYTES. Requests can be granted from that last edge onward.
- Reset asserted mid-transaction aborts it: no valid pulse, captured write discarded. Reset mid-sweep restarts the sweep at 0.

## Structure
- Shared defines file holds:
  - FSM state encodings.
  - `BYTES` and the wait-counter width derivation.
  - Port-id constants `PORT_I`/`PORT_D`.
- Sub-module `risc16_byte_array`:
  - Storage: MEM_SIZE×8 array.
  - One BYTES-wide read port and one BYTES-wide lane-enabled write port.
  - Handles modulo-address wrap internally.
  - Used by both the access path and the clear engine.
- The top level holds the FSM, arbiter, wait counter, clear counter and output registers.

## Test plan
- Reset with INIT_CLEAR=1, MEM_SIZE=256 → `busy`=1 for exactly 128 cycles. A data read of 0x0010 afterwards returns 0x0000.
- WAIT_CYCLES=2:
  - Data write 0xBEEF to 0x0040 with `dByteEn`=2'b11.
  - Then read 0x0040 → `dValid` exactly 3 edges after acceptance, `dDataOut`=0xBEEF.
  - Instruction read 0x0040 → `iData`=0xBEEF.
- Write 0x1234 to 0x0040 with `dByteEn`=2'b01 over 0xBEEF → a read returns 0xBE34.
- MEM_SIZE=256, write 0xA55A at address 0x00FF → byte 0xFF=0xA5, byte 0x00=0x5A. A read at 0x0000 returns 0x5Axx.
- Both ports request continuously for 6 grants → grants alternate D,I,D,I,D,I, with each valid a single cycle.
- Assert `rst` low during WAIT of a write to 0x0080 → no `dValid`, and the location is unchanged after a re-read.

Source files
------------

// File: rtl/risc16_banked_memory_pkg.sv
// Shared definitions for the RiSC-16 banked main memory.
//   - FSM state encoding
//   - lane-count and counter-width helpers
//   - port identifiers used by the arbiter and capture registers
package risc16_banked_memory_pkg;

    typedef enum logic [1:0] {
        StClear  = 2'd0,
        StIdle   = 2'd1,
        StWait   = 2'd2,
        StAccess = 2'd3
    } memState_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned MAX_WAIT_CYCLES = 15;
    localparam int unsigned WAIT_CNT_WIDTH  = $clog2(MAX_WAIT_CYCLES + 1);

    // Bytes per word.
    function automatic int unsigned bytesOf(input int unsigned wordLength);
        return wordLength / 8;
    endfunction

    // Counter width able to index n items (at least one bit).
    function automatic int unsigned cntWidth(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/risc16_byte_array.sv
// Byte-organised storage for risc16_banked_memory.
//   clk      : write clock
//   rdAddr   : byte address of the word to read (combinational read)
//   rdData   : BYTES bytes, byte at rdAddr in the MSB lane
//   wrEn     : write strobe
//   wrAddr   : byte address of the word to write
//   wrLanes  : lane enables, MSB is the byte at wrAddr
//   wrData   : write data, MSB lane is the byte at wrAddr
// Consecutive bytes of a word wrap modulo MEM_SIZE.
module risc16_byte_array
    import risc16_banked_memory_pkg::*;
#(
    parameter int unsigned BYTES      = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MEM_SIZE   = 65536
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [BYTES*8-1:0]    rdData,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [BYTES-1:0]      wrLanes,
    input  logic [BYTES*8-1:0]    wrData
);

    localparam int unsigned IDX_W = cntWidth(MEM_SIZE);

    logic [7:0] mem [MEM_SIZE];

    // Address bits above the array size are don't-care (modulo wrap).
    logic unusedAddrBits;
    assign unusedAddrBits = ^{rdAddr, wrAddr};

    // Index of lane k of the word at base; truncation to IDX_W gives the wrap.
    function automatic logic [IDX_W-1:0] laneIdx(input logic [ADDR_WIDTH-1:0] base,
                                                 input int unsigned k);
        return base[IDX_W-1:0] + IDX_W'(k);
    endfunction

    always_comb begin
        rdData = '0;
        for (int k = 0; k < BYTES; k++) begin
            rdData[(BYTES-1-k)*8 +: 8] = mem[laneIdx(rdAddr, k)];
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int k = 0; k < BYTES; k++) begin
                if (wrLanes[BYTES-1-k]) begin
                    mem[laneIdx(wrAddr, k)] <= wrData[(BYTES-1-k)*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/risc16_banked_memory.sv
// Byte-addressed big-endian main memory for RiSC-16 cores.
//   clk, rst         : clock, asynchronous active-low reset
//   clearReq, busy   : start a zeroing sweep (sampled in idle) / sweep running
//   iReq, iAddr      : instruction fetch request and byte address
//   iData, iValid    : fetched word / one-cycle completion pulse
//   dReq, dWe        : data request, 1 = write
//   dByteEn          : write lane enables, MSB = byte at dAddr
//   dAddr, dDataIn   : data byte address and write data
//   dDataOut, dValid : read data / one-cycle completion pulse
// Both ports share one byte array through an alternating-priority arbiter.
module risc16_banked_memory
    import risc16_banked_memory_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned MEM_SIZE    = 65536,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned INIT_CLEAR  = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clearReq,
    output logic                              busy,
    input  logic                              iReq,
    input  logic [ADDR_WIDTH-1:0]             iAddr,
    output logic [WORD_LENGTH-1:0]            iData,
    output logic                              iValid,
    input  logic                              dReq,
    input  logic                              dWe,
    input  logic [bytesOf(WORD_LENGTH)-1:0]   dByteEn,
    input  logic [ADDR_WIDTH-1:0]             dAddr,
    input  logic [WORD_LENGTH-1:0]            dDataIn,
    output logic [WORD_LENGTH-1:0]            dDataOut,
    output logic                              dValid
);

    localparam int unsigned BYTES = bytesOf(WORD_LENGTH);
    localparam int unsigned WORDS = MEM_SIZE / BYTES;
    localparam int unsigned CLR_W = cntWidth(WORDS);

    localparam logic [CLR_W-1:0] CLEAR_LAST = CLR_W'(WORDS - 1);
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST =
        (WAIT_CYCLES > 0) ? WAIT_CNT_WIDTH'(WAIT_CYCLES - 1) : '0;
    localparam memState_e RESET_STATE = (INIT_CLEAR != 0) ? StClear : StIdle;
    localparam memState_e GRANT_STATE = (WAIT_CYCLES > 0) ? StWait : StAccess;

    memState_e                 state;
    logic                      lastGrant;
    logic                      capPort;
    logic                      capWe;
    logic [ADDR_WIDTH-1:0]     capAddr;
    logic [BYTES-1:0]          capByteEn;
    logic [WORD_LENGTH-1:0]    capData;
    logic [WAIT_CNT_WIDTH-1:0] waitCnt;
    logic [CLR_W-1:0]          clearCnt;

    logic                      grantD;
    logic                      clearing;
    logic                      accessWrite;
    logic [ADDR_WIDTH-1:0]     clearAddr;
    logic                      wrEn;
    logic [ADDR_WIDTH-1:0]     wrAddr;
    logic [BYTES-1:0]          wrLanes;
    logic [WORD_LENGTH-1:0]    wrData;
    logic [WORD_LENGTH-1:0]    rdData;

    // Data wins when alone, or on a tie when instruction was granted last.
    assign grantD = dReq && (!iReq || (lastGrant == PORT_I));

    // busy low in StClear marks the arming cycle that follows reset release.
    assign clearing    = (state == StClear) && busy;
    assign accessWrite = (state == StAccess) && (capPort == PORT_D) && capWe;
    assign clearAddr   = ADDR_WIDTH'(clearCnt) * ADDR_WIDTH'(BYTES);

    always_comb begin
        wrEn    = clearing || accessWrite;
        wrAddr  = capAddr;
        wrLanes = capByteEn;
        wrData  = capData;
        if (clearing) begin
            wrAddr  = clearAddr;
            wrLanes = '1;
            wrData  = '0;
        end
    end

    risc16_byte_array #(
        .BYTES      (BYTES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (MEM_SIZE)
    ) uArray (
        .clk     (clk),
        .rdAddr  (capAddr),
        .rdData  (rdData),
        .wrEn    (wrEn),
        .wrAddr  (wrAddr),
        .wrLanes (wrLanes),
        .wrData  (wrData)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RESET_STATE;
            lastGrant <= PORT_I;
            capPort   <= PORT_I;
            capWe     <= 1'b0;
            capAddr   <= '0;
            capByteEn <= '0;
            capData   <= '0;
            waitCnt   <= '0;
            clearCnt  <= '0;
            busy      <= 1'b0;
            iValid    <= 1'b0;
            dValid    <= 1'b0;
            iData     <= '0;
            dDataOut  <= '0;
        end else begin
            iValid <= 1'b0;
            dValid <= 1'b0;
            unique case (state)
                StClear: begin
                    if (!busy) begin
                        busy <= 1'b1;
                    end else if (clearCnt == CLEAR_LAST) begin
                        busy     <= 1'b0;
                        clearCnt <= '0;
                        state    <= StIdle;
                    end else begin
                        clearCnt <= clearCnt + 1'b1;
                    end
                end
                StIdle: begin
                    if (clearReq) begin
                        busy     <= 1'b1;
                        clearCnt <= '0;
                        state    <= StClear;
                    end else if (iReq || dReq) begin
                        capPort   <= grantD ? PORT_D : PORT_I;
                        capAddr   <= grantD ? dAddr : iAddr;
                        capWe     <= grantD && dWe;
                        capByteEn <= dByteEn;
                        capData   <= dDataIn;
                        waitCnt   <= '0;
                        state     <= GRANT_STATE;
                    end
                end
                StWait: begin
                    if (waitCnt == WAIT_LAST) begin
                        state <= StAccess;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                StAccess: begin
                    if (capPort == PORT_D) begin
                        if (!capWe) begin
                            dDataOut <= rdData;
                        end
                        dValid <= 1'b1;
                    end else begin
                        iData  <= rdData;
                        iValid <= 1'b1;
                    end
                    lastGrant <= capPort;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
